// File: rtl/regfile_dump_seq.sv
`default_nettype none
// ============================================================================
// Module   : regfile_dump_seq
// Brief    : Debug sequencer that walks the register-file read mux over an
//            index range. For each register it streams an index byte, then
//            the data bytes MSB first, over a valid/ready byte link to UART TX.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_dump_seq #(
  // Register word width; legal values are 8, 16, 24 and 32.
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       first_reg,
  input  logic [4:0]       last_reg,
  output logic [4:0]       rf_select,
  input  logic [WIDTH-1:0] rf_data,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic             done
);

  localparam int         NBYTES    = WIDTH / 8;
  // Two bits cover the byte counter for up to four data bytes.
  localparam logic [1:0] BCNT_LAST = 2'(NBYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_SEND_IDX  = 3'd2,
    ST_SEND_DATA = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  state_t           state;
  logic [4:0]       idx;
  logic [4:0]       last;
  logic [1:0]       bcnt;
  logic [WIDTH-1:0] sh;

  logic [WIDTH-1:0] sh_next;
  logic [4:0]       idx_next;
  logic             handshake;

  // The byte that follows the current one, and the next index (wraps 31->0).
  assign sh_next   = sh << 8;
  assign idx_next  = idx + 5'd1;
  assign handshake = tx_valid & tx_ready;

  // Sequencer: state and every output are registered together here, so the
  // outputs change only on a state transition or an accepted byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      idx       <= 5'd0;
      last      <= 5'd0;
      bcnt      <= 2'd0;
      sh        <= '0;
      rf_select <= 5'd0;
      tx_data   <= 8'd0;
      tx_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            idx       <= first_reg;
            last      <= last_reg;
            rf_select <= first_reg;
            busy      <= 1'b1;
            state     <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          // The mux has had the whole cycle to settle on rf_select.
          sh       <= rf_data;
          tx_valid <= 1'b1;
          tx_data  <= {3'b000, idx};
          state    <= ST_SEND_IDX;
        end

        ST_SEND_IDX: begin
          if (handshake) begin
            bcnt    <= BCNT_LAST;
            tx_data <= sh[WIDTH-1 -: 8];
            state   <= ST_SEND_DATA;
          end
        end

        ST_SEND_DATA: begin
          if (handshake) begin
            sh <= sh_next;
            if (bcnt != 2'd0) begin
              bcnt    <= bcnt - 2'd1;
              tx_data <= sh_next[WIDTH-1 -: 8];
            end else if (idx == last) begin
              tx_valid  <= 1'b0;
              tx_data   <= 8'd0;
              rf_select <= 5'd0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= ST_DONE;
            end else begin
              idx       <= idx_next;
              rf_select <= idx_next;
              tx_valid  <= 1'b0;
              tx_data   <= 8'd0;
              state     <= ST_LOAD;
            end
          end
        end

        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_dump_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_dump_seq
// Brief    : Self-checking bench for regfile_dump_seq with a byte scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_dump_seq;

  localparam int WIDTH = 32;

  logic             clk;
  logic             reset;
  logic             start;
  logic [4:0]       first_reg;
  logic [4:0]       last_reg;
  logic [4:0]       rf_select;
  logic [WIDTH-1:0] rf_data;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             busy;
  logic             done;

  regfile_dump_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .first_reg (first_reg),
    .last_reg  (last_reg),
    .rf_select (rf_select),
    .rf_data   (rf_data),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .done      (done)
  );

  // Register-file model: every register reads as A5_0000_<index>.
  assign rf_data = 32'hA500_0000 | {27'd0, rf_select};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int       cyc;
  int       n_cmp;
  int       n_err;
  int       done_cnt;
  int       done_cyc;
  int       busy_cnt;
  int       byte_cnt;
  int       start_cyc;
  logic [7:0] exp_q[$];
  logic       prev_valid;
  logic       prev_hs;
  logic [7:0] prev_data;

  // Edge counter: after edge k (and #1) cyc equals k.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor on the falling edge: scoreboard pops, handshake stability, done/busy.
  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      if (prev_valid && !prev_hs) begin
        n_cmp++;
        if (tx_valid !== 1'b1 || tx_data !== prev_data) begin
          n_err++;
          $display("FAIL hold_stable: valid=%b data=%02h required valid=1 data=%02h",
                   tx_valid, tx_data, prev_data);
        end
      end
      if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
        n_cmp++;
        byte_cnt++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL byte_extra: got %02h required no byte", tx_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (tx_data !== e) begin
            n_err++;
            $display("FAIL byte_stream: got %02h required %02h", tx_data, e);
          end
        end
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy === 1'b1) busy_cnt++;
      prev_valid = tx_valid;
      prev_hs    = tx_valid & tx_ready;
      prev_data  = tx_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue the expected byte stream for one dump.
  task automatic push_dump(input logic [4:0] f, input logic [4:0] l);
    logic [4:0] i;
    i = f;
    forever begin
      exp_q.push_back({3'b000, i});
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h00);
      exp_q.push_back({3'b000, i});
      if (i == l) break;
      i = i + 5'd1;
    end
  endtask

  // Pulse start for one edge; start_cyc is the edge that samples it.
  task automatic start_dump(input logic [4:0] f, input logic [4:0] l);
    first_reg = f;
    last_reg  = l;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    start_cyc = cyc;
    n_cmp++;
    if (busy !== 1'b1 || rf_select !== f) begin
      n_err++;
      $display("FAIL load_entry: busy=%b sel=%0d required busy=1 sel=%0d", busy, rf_select, f);
    end
  endtask

  // Wait for a done pulse within a cycle budget.
  task automatic wait_done(input int base, input int limit);
    while (done_cnt == base && cyc < start_cyc + limit) tick();
    tick();
    n_cmp++;
    if (done_cnt == base) begin
      n_err++;
      $display("FAIL done_timeout: no done within %0d cycles", limit);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; first_reg = 5'd3; last_reg = 5'd4; tx_ready = 1'b1;
    tick(); tick();
    n_cmp++;
    if ({rf_select, tx_data, tx_valid, busy, done} !== 16'd0) begin
      n_err++;
      $display("FAIL reset_outputs: sel=%0d data=%02h valid=%b busy=%b done=%b required all 0",
               rf_select, tx_data, tx_valid, busy, done);
    end
    reset = 1'b0; start = 1'b0;
    tick(); tick();
    n_cmp++;
    if (busy !== 1'b0 || tx_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: busy=%b valid=%b required 0 0", busy, tx_valid);
    end
  endtask

  task automatic test_full_dump();
    int d0, b0, n0;
    d0 = done_cnt; b0 = busy_cnt; n0 = byte_cnt;
    push_dump(5'd0, 5'd31);
    start_dump(5'd0, 5'd31);
    wait_done(d0, 400);
    n_cmp++;
    if (done_cyc !== start_cyc + 192) begin
      n_err++;
      $display("FAIL full_done_time: got +%0d required +192", done_cyc - start_cyc);
    end
    n_cmp++;
    if (busy_cnt - b0 !== 192) begin
      n_err++;
      $display("FAIL full_busy_cycles: got %0d required 192", busy_cnt - b0);
    end
    n_cmp++;
    if (byte_cnt - n0 !== 160 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL full_byte_count: got %0d left %0d required 160 left 0",
               byte_cnt - n0, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    int d0, n0;
    d0 = done_cnt; n0 = byte_cnt;
    push_dump(5'd0, 5'd31);
    start_dump(5'd0, 5'd31);
    while (cyc < start_cyc + 8) tick();
    tx_ready = 1'b0;
    repeat (10) tick();
    tx_ready = 1'b1;
    wait_done(d0, 400);
    n_cmp++;
    if (done_cyc !== start_cyc + 202) begin
      n_err++;
      $display("FAIL stall_done_time: got +%0d required +202", done_cyc - start_cyc);
    end
    n_cmp++;
    if (byte_cnt - n0 !== 160 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL stall_byte_count: got %0d required 160", byte_cnt - n0);
    end
  endtask

  task automatic test_wrap();
    int d0, n0;
    d0 = done_cnt; n0 = byte_cnt;
    push_dump(5'd30, 5'd1);
    start_dump(5'd30, 5'd1);
    wait_done(d0, 100);
    n_cmp++;
    if (byte_cnt - n0 !== 20 || exp_q.size() != 0 || done_cyc !== start_cyc + 24) begin
      n_err++;
      $display("FAIL wrap_count: bytes %0d done +%0d required bytes 20 done +24",
               byte_cnt - n0, done_cyc - start_cyc);
    end
  endtask

  task automatic test_single_start_busy();
    int d0, n0;
    d0 = done_cnt; n0 = byte_cnt;
    push_dump(5'd5, 5'd5);
    start_dump(5'd5, 5'd5);
    tick(); tick(); tick();
    first_reg = 5'd9; last_reg = 5'd12; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    n_cmp++;
    if (done_cnt - d0 !== 1 || byte_cnt - n0 !== 5 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL single_reg: dones %0d bytes %0d required dones 1 bytes 5",
               done_cnt - d0, byte_cnt - n0);
    end
    n_cmp++;
    if (done_cyc !== start_cyc + 6 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL single_done_time: got +%0d busy=%b required +6 busy=0",
               done_cyc - start_cyc, busy);
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    d0 = done_cnt;
    push_dump(5'd0, 5'd31);
    start_dump(5'd0, 5'd31);
    while (cyc < start_cyc + 21) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    n_cmp++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rf_select !== 5'd0) begin
      n_err++;
      $display("FAIL midreset_outputs: valid=%b busy=%b done=%b sel=%0d required 0",
               tx_valid, busy, done, rf_select);
    end
    repeat (5) tick();
    n_cmp++;
    if (done_cnt !== d0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_nodone: dones %0d busy=%b required 0 0", done_cnt - d0, busy);
    end
    push_dump(5'd7, 5'd8);
    start_dump(5'd7, 5'd8);
    wait_done(d0, 100);
    n_cmp++;
    if (exp_q.size() != 0 || done_cyc !== start_cyc + 12) begin
      n_err++;
      $display("FAIL midreset_restart: left %0d done +%0d required left 0 done +12",
               exp_q.size(), done_cyc - start_cyc);
    end
  endtask

  initial begin
    cyc = 0; n_cmp = 0; n_err = 0; done_cnt = 0; done_cyc = 0;
    busy_cnt = 0; byte_cnt = 0; start_cyc = 0;
    prev_valid = 1'b0; prev_hs = 1'b0; prev_data = 8'd0;
    reset = 1'b1; start = 1'b0; first_reg = 5'd0; last_reg = 5'd0; tx_ready = 1'b1;
    test_reset();
    test_full_dump();
    test_backpressure();
    test_wrap();
    test_single_start_busy();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
